// File: rtl/enigma_stream_decoder.sv
// Enigma decipher datapath: 3-rotor machine (fixed ring A, no plugboard, reflector B)
// between a ciphertext valid/ready stream and a plaintext valid/ready stream.
module enigma_stream_decoder #(
  parameter int ROTOR_L   = 1,
  parameter int ROTOR_M   = 2,
  parameter int ROTOR_R   = 3,
  parameter int CASE_KEEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pos_load,
  input  logic [4:0]  pos_l,
  input  logic [4:0]  pos_m,
  input  logic [4:0]  pos_r,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_char,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_char,
  output logic        out_err,
  output logic [14:0] rot_pos,
  output logic        self_err
);

  // state | meaning
  // IDLE  | waiting for a byte or a position load
  // STEP  | advance rotors (right always, middle/left by notch, double-step)
  // FWD   | right->middle->left forward path, registered
  // REV   | reflector, inverse wheels, ASCII conversion
  // OUT   | present result until out_ready
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_STEP = 3'd1;
  localparam logic [2:0] S_FWD  = 3'd2;
  localparam logic [2:0] S_REV  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  localparam logic [207:0] W_I    = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [207:0] W_II   = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  localparam logic [207:0] W_III  = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
  localparam logic [207:0] V_I    = "UWYGADFPVZBECKMTHXSLRINQOJ";
  localparam logic [207:0] V_II   = "AJPCZWRLFBDKOTYUQGENHXMIVS";
  localparam logic [207:0] V_III  = "TAGBPCSDQEUFVNZHYIXJWLRKOM";
  localparam logic [207:0] REFL_B = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

  localparam logic [207:0] WL = (ROTOR_L == 1) ? W_I : (ROTOR_L == 2) ? W_II : W_III;
  localparam logic [207:0] WM = (ROTOR_M == 1) ? W_I : (ROTOR_M == 2) ? W_II : W_III;
  localparam logic [207:0] WR = (ROTOR_R == 1) ? W_I : (ROTOR_R == 2) ? W_II : W_III;
  localparam logic [207:0] VL = (ROTOR_L == 1) ? V_I : (ROTOR_L == 2) ? V_II : V_III;
  localparam logic [207:0] VM = (ROTOR_M == 1) ? V_I : (ROTOR_M == 2) ? V_II : V_III;
  localparam logic [207:0] VR = (ROTOR_R == 1) ? V_I : (ROTOR_R == 2) ? V_II : V_III;
  localparam logic [4:0]   NM = (ROTOR_M == 1) ? 5'd16 : (ROTOR_M == 2) ? 5'd4 : 5'd21;
  localparam logic [4:0]   NR = (ROTOR_R == 1) ? 5'd16 : (ROTOR_R == 2) ? 5'd4 : 5'd21;

  // Tables are ASCII strings, letter 'A' in the top byte.
  function automatic logic [4:0] lookup(input logic [207:0] t, input logic [4:0] i);
    logic [7:0] k;
    k = {3'b000, 5'd25 - i} << 3;
    return 5'(t[k +: 8] - 8'd65);
  endfunction

  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (s[5]) s = s + 6'd26;
    return s[4:0];
  endfunction

  function automatic logic [4:0] wheel(input logic [207:0] t, input logic [4:0] c,
                                       input logic [4:0] p);
    return sub26(lookup(t, add26(c, p)), p);
  endfunction

  function automatic logic [4:0] inc26(input logic [4:0] x);
    return (x == 5'd25) ? 5'd0 : x + 5'd1;
  endfunction

  logic [2:0] state;
  logic [4:0] pl, pm, pr;
  logic [4:0] cur;
  logic       lower;
  logic [4:0] fwd_q;

  logic       is_upper, is_lower;
  logic [4:0] in_idx;
  logic [4:0] fwd_c;
  logic [4:0] rev_c;
  logic [7:0] rev_ascii;

  assign is_upper  = (in_char >= 8'd65) && (in_char <= 8'd90);
  assign is_lower  = (in_char >= 8'd97) && (in_char <= 8'd122);
  assign in_idx    = is_lower ? 5'(in_char - 8'd97) : 5'(in_char - 8'd65);

  assign fwd_c     = wheel(WL, wheel(WM, wheel(WR, cur, pr), pm), pl);
  assign rev_c     = wheel(VR, wheel(VM, wheel(VL, lookup(REFL_B, fwd_q), pl), pm), pr);
  assign rev_ascii = ((CASE_KEEP != 0) && lower) ? 8'd97 + {3'b000, rev_c}
                                                 : 8'd65 + {3'b000, rev_c};

  assign in_ready  = rst && (state == S_IDLE) && !pos_load;
  assign out_valid = (state == S_OUT);
  assign rot_pos   = {pl, pm, pr};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      pl       <= 5'd0;
      pm       <= 5'd0;
      pr       <= 5'd0;
      cur      <= 5'd0;
      lower    <= 1'b0;
      fwd_q    <= 5'd0;
      out_char <= 8'd0;
      out_err  <= 1'b0;
      self_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pos_load) begin
            pl       <= (pos_l > 5'd25) ? 5'd0 : pos_l;
            pm       <= (pos_m > 5'd25) ? 5'd0 : pos_m;
            pr       <= (pos_r > 5'd25) ? 5'd0 : pos_r;
            self_err <= 1'b0;
          end else if (in_valid) begin
            if (is_upper || is_lower) begin
              cur   <= in_idx;
              lower <= is_lower;
              state <= S_STEP;
            end else begin
              out_char <= in_char;
              out_err  <= 1'b1;
              state    <= S_OUT;
            end
          end
        end
        S_STEP: begin
          // Middle at its own notch steps again together with the left wheel: double-step.
          pr <= inc26(pr);
          if ((pr == NR) || (pm == NM)) pm <= inc26(pm);
          if (pm == NM) pl <= inc26(pl);
          state <= S_FWD;
        end
        S_FWD: begin
          fwd_q <= fwd_c;
          state <= S_REV;
        end
        S_REV: begin
          out_char <= rev_ascii;
          out_err  <= 1'b0;
          if (rev_c == cur) self_err <= 1'b1;
          state <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_stream_decoder.sv
// Directed bench for enigma_stream_decoder (rotors I-II-III, reflector B, CASE_KEEP=1).
module tb_enigma_stream_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        pos_load;
  logic [4:0]  pos_l, pos_m, pos_r;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_char;
  logic        out_err;
  logic [14:0] rot_pos;
  logic        self_err;

  int passed = 0;
  int total  = 0;

  enigma_stream_decoder #(.ROTOR_L(1), .ROTOR_M(2), .ROTOR_R(3), .CASE_KEEP(1)) dut (
    .clk(clk), .rst(rst), .pos_load(pos_load), .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char), .out_err(out_err),
    .rot_pos(rot_pos), .self_err(self_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
    pos_l = l; pos_m = m; pos_r = r; pos_load = 1'b1;
    tick();
    pos_load = 1'b0;
  endtask

  // lat counts edges from the one preceding the handshake edge to the first out_valid.
  task automatic send(input logic [7:0] c, output logic [7:0] oc, output logic oe,
                      output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    in_valid = 1'b1; in_char = c;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    oc = out_char; oe = out_err;
    if (out_ready) tick();
  endtask

  initial begin
    logic [7:0] oc;
    logic       oe;
    int         lat;
    string      plain, cipher;
    logic       seen, stable, rdy_seen;

    rst = 1'b0; pos_load = 1'b0; pos_l = 0; pos_m = 0; pos_r = 0;
    in_valid = 1'b0; in_char = 8'h00; out_ready = 1'b1;
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_rot_pos", rot_pos, 0);
    check("rst_out_char", out_char, 0);
    check("rst_out_err", out_err, 0);
    check("rst_self_err", self_err, 0);
    rst = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 1);

    // 1: single letter, latency
    load(0, 0, 0);
    send("A", oc, oe, lat);
    check("t1_char", oc, "B");
    check("t1_err", oe, 0);
    check("t1_lat", lat, 4);
    check("t1_pos", rot_pos, {5'd0, 5'd0, 5'd1});

    // 2: known sequence and reciprocity
    plain = "AAAAA"; cipher = "BDZGO";
    load(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      send(plain[i], oc, oe, lat);
      check("t2_enc", oc, cipher[i]);
    end
    check("t2_pos", rot_pos, {5'd0, 5'd0, 5'd5});
    load(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      send(cipher[i], oc, oe, lat);
      check("t2_dec", oc, plain[i]);
    end
    check("t2_self_err", self_err, 0);

    // 3: double-step from ADU
    load(0, 3, 20);
    send("A", oc, oe, lat);
    check("t3_pos1", rot_pos, {5'd0, 5'd3, 5'd21});
    send("A", oc, oe, lat);
    check("t3_pos2", rot_pos, {5'd0, 5'd4, 5'd22});
    send("A", oc, oe, lat);
    check("t3_pos3", rot_pos, {5'd1, 5'd5, 5'd23});

    // 4: non-letter pass-through, lowercase
    load(0, 0, 0);
    send(8'h35, oc, oe, lat);
    check("t4_char", oc, 8'h35);
    check("t4_err", oe, 1);
    check("t4_lat", lat, 1);
    check("t4_pos", rot_pos, 0);
    send("a", oc, oe, lat);
    check("t4_lower", oc, "b");
    check("t4_lower_err", oe, 0);

    // 5: backpressure, pos_load ignored outside IDLE
    out_ready = 1'b0;
    in_valid = 1'b1; in_char = "A";
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    check("t5_lat", lat, 4);
    stable = 1'b1; rdy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_char !== "D" || out_valid !== 1'b1) stable = 1'b0;
      if (in_ready) rdy_seen = 1'b1;
      if (i == 5) begin pos_l = 9; pos_m = 9; pos_r = 9; pos_load = 1'b1; end
      else pos_load = 1'b0;
      tick();
    end
    pos_load = 1'b0;
    check("t5_stable", stable, 1);
    check("t5_no_ready", rdy_seen, 0);
    check("t5_pos", rot_pos, {5'd0, 5'd0, 5'd2});
    out_ready = 1'b1;
    tick();
    check("t5_drop", out_valid, 0);

    // 6: load beats in_valid; out-of-range position clamps to 0
    pos_l = 30; pos_m = 6; pos_r = 7; pos_load = 1'b1;
    in_valid = 1'b1; in_char = "A";
    #1;
    check("t6_ready_low", in_ready, 0);
    tick();
    pos_load = 1'b0; in_valid = 1'b0;
    check("t6_pos", rot_pos, {5'd0, 5'd6, 5'd7});
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("t6_no_out", seen, 0);
    check("t6_pos_kept", rot_pos, {5'd0, 5'd6, 5'd7});

    // reset during REV aborts the byte
    in_valid = 1'b1; in_char = "Q";
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_ready", in_ready, 0);
    check("t6_rst_pos", rot_pos, 0);
    check("t6_rst_char", out_char, 0);
    check("t6_rst_err", out_err, 0);
    tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("t6_abort", seen, 0);
    check("t6_idle", in_ready, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
